// File: rtl/bus_arbitro.sv
// Round-robin arbiter/sequencer sharing one operand bus and its ALU among NREQ requesters.
// Drives operand A then B, waits RES_LAT cycles, captures C and pulses done to the winner.
module bus_arbitro #(
    parameter int NREQ    = 4,
    parameter int RES_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] op_flat,
    input  logic [8*NREQ-1:0] a_flat,
    input  logic [8*NREQ-1:0] b_flat,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic [7:0]        resultado,
    output logic              ocupado,
    output logic [1:0]        dispositivo,
    output logic [1:0]        operacion,
    output logic [7:0]        entrada,
    output logic              bus_valido,
    input  logic [7:0]        C
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CARGA_A,
        S_CARGA_B,
        S_ESPERA,
        S_ENTREGA
    } state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [3:0] cnt;
    logic [1:0] op_q;
    logic [7:0] a_q;
    logic [7:0] b_q;

    logic       win_found;
    logic [1:0] win_idx;
    logic [1:0] idx;
    logic [1:0] win_op;
    logic [7:0] win_a;
    logic [7:0] win_b;

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = '0;
        win_op    = '0;
        win_a     = '0;
        win_b     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr + 2'(k);
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (win_idx == 2'(k)) begin
                win_op = op_flat[2*k +: 2];
                win_a  = a_flat[8*k +: 8];
                win_b  = b_flat[8*k +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ptr         <= '0;
            cnt         <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            grant       <= '0;
            done        <= '0;
            resultado   <= '0;
            ocupado     <= 1'b0;
            dispositivo <= '0;
            operacion   <= '0;
            entrada     <= '0;
            bus_valido  <= 1'b0;
        end else begin
            done <= '0;
            case (state)
                // The delivery edge doubles as the arbitration edge, giving one
                // transaction every 3+RES_LAT cycles under continuous demand.
                S_IDLE, S_ENTREGA: begin
                    grant      <= '0;
                    bus_valido <= 1'b0;
                    if (win_found) begin
                        state            <= S_CARGA_A;
                        grant[win_idx]   <= 1'b1;
                        dispositivo      <= win_idx;
                        operacion        <= win_op;
                        op_q             <= win_op;
                        a_q              <= win_a;
                        b_q              <= win_b;
                        ptr              <= win_idx + 2'd1;
                        ocupado          <= 1'b1;
                    end else begin
                        state       <= S_IDLE;
                        ocupado     <= 1'b0;
                        dispositivo <= '0;
                        operacion   <= '0;
                    end
                end
                S_CARGA_A: begin
                    entrada    <= a_q;
                    operacion  <= op_q;
                    bus_valido <= 1'b1;
                    state      <= S_CARGA_B;
                end
                S_CARGA_B: begin
                    entrada    <= b_q;
                    bus_valido <= 1'b1;
                    cnt        <= 4'(RES_LAT);
                    state      <= S_ESPERA;
                end
                S_ESPERA: begin
                    entrada    <= '0;
                    bus_valido <= 1'b0;
                    cnt        <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        resultado <= C;
                        done      <= grant;
                        state     <= S_ENTREGA;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbitro.sv
// Directed bench for bus_arbitro: a RES_LAT=2 instance with an add/sub datapath model
// and a RES_LAT=1 instance fed from a bench-driven result value.
module tb_bus_arbitro;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req, grant, done;
    logic [7:0]  op_flat;
    logic [31:0] a_flat, b_flat;
    logic [7:0]  resultado, entrada, c_bus;
    logic        ocupado, bus_valido;
    logic [1:0]  dispositivo, operacion;

    logic [3:0]  req1, grant1, done1;
    logic [7:0]  op_flat1;
    logic [31:0] a_flat1, b_flat1;
    logic [7:0]  resultado1, entrada1, c1;
    logic        ocupado1, bus_valido1;
    logic [1:0]  dispositivo1, operacion1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bus_arbitro #(.NREQ(4), .RES_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op_flat(op_flat), .a_flat(a_flat),
        .b_flat(b_flat), .grant(grant), .done(done), .resultado(resultado),
        .ocupado(ocupado), .dispositivo(dispositivo), .operacion(operacion),
        .entrada(entrada), .bus_valido(bus_valido), .C(c_bus)
    );

    bus_arbitro #(.NREQ(4), .RES_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .op_flat(op_flat1), .a_flat(a_flat1),
        .b_flat(b_flat1), .grant(grant1), .done(done1), .resultado(resultado1),
        .ocupado(ocupado1), .dispositivo(dispositivo1), .operacion(operacion1),
        .entrada(entrada1), .bus_valido(bus_valido1), .C(c1)
    );

    // Datapath model: latch the two bus beats, then add (op 00) or subtract (op 01).
    logic [7:0] m_a, m_b;
    logic       m_second;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a <= '0; m_b <= '0; m_second <= 1'b0;
        end else if (bus_valido) begin
            if (!m_second) m_a <= entrada;
            else           m_b <= entrada;
            m_second <= ~m_second;
        end
    end
    assign c_bus = (operacion == 2'b01) ? m_a - m_b : m_a + m_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    logic [3:0] exp_all[5]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] exp_two[4]  = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};
    logic [1:0] exp_disp[4] = '{2'd0, 2'd3, 2'd0, 2'd3};

    initial begin
        rst_n = 1'b0; req = '0; op_flat = '0; a_flat = '0; b_flat = '0;
        req1 = '0; op_flat1 = '0; a_flat1 = '0; b_flat1 = '0; c1 = 8'h11;
        #3;
        check("rst_grant", grant, 0);
        check("rst_done", done, 0);
        check("rst_resultado", resultado, 0);
        check("rst_ocupado", ocupado, 0);
        check("rst_bus_valido", bus_valido, 0);
        check("rst_entrada", entrada, 0);
        check("rst_dispositivo", dispositivo, 0);
        step(1);
        rst_n = 1'b1;

        // Single requester 1, adder: 10 + 8 = 18
        req = 4'b0010; op_flat = 8'h00; a_flat = 32'd10 << 8; b_flat = 32'd8 << 8;
        step(1);
        req = '0;
        check("s_grant_e0", grant, 4'b0010);
        check("s_ocupado_e0", ocupado, 1);
        check("s_disp_e0", dispositivo, 1);
        check("s_bv_e0", bus_valido, 0);
        step(1);
        check("s_entrada_a", entrada, 10);
        check("s_bv_e1", bus_valido, 1);
        check("s_grant_e1", grant, 4'b0010);
        step(1);
        check("s_entrada_b", entrada, 8);
        check("s_bv_e2", bus_valido, 1);
        step(1);
        check("s_bv_e3", bus_valido, 0);
        check("s_entrada_e3", entrada, 0);
        check("s_done_e3", done, 0);
        step(1);
        check("s_done_e4", done, 4'b0010);
        check("s_resultado", resultado, 18);
        check("s_grant_e4", grant, 4'b0010);
        step(1);
        check("s_done_e5", done, 0);
        check("s_grant_e5", grant, 0);
        check("s_ocupado_e5", ocupado, 0);
        check("s_resultado_hold", resultado, 18);

        // Reset during S_ESPERA, then pointer restarts at 0
        req = 4'b0010;
        step(1);
        req = '0;
        step(3);
        rst_n = 1'b0;
        #1;
        check("mr_grant", grant, 0);
        check("mr_done", done, 0);
        check("mr_resultado", resultado, 0);
        check("mr_ocupado", ocupado, 0);
        check("mr_bus_valido", bus_valido, 0);
        step(2);
        check("mr_done_held", done, 0);
        req = 4'b0100;
        rst_n = 1'b1;
        step(1);
        req = '0;
        check("mr_grant_after", grant, 4'b0100);
        check("mr_disp_after", dispositivo, 2);
        step(5);
        check("mr_ocupado_end", ocupado, 0);

        // All four requesting, held
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step(i == 0 ? 1 : 5);
            check($sformatf("all_grant_%0d", i), grant, exp_all[i]);
            check($sformatf("all_disp_%0d", i), dispositivo, i % 4);
        end
        step(4);
        check("all_grant_mid", grant, 4'b0001);
        check("all_done_mid", done, 4'b0001);
        req = '0;
        step(1);
        check("all_idle", ocupado, 0);

        // Two persistent requesters 0 and 3
        do_reset();
        req = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            step(i == 0 ? 1 : 5);
            check($sformatf("two_grant_%0d", i), grant, exp_two[i]);
            check($sformatf("two_disp_%0d", i), dispositivo, exp_disp[i]);
        end
        req = '0;
        step(5);
        check("two_idle", ocupado, 0);

        // Request dropped after S_CARGA_A, subtractor: 8 - 5 = 3
        do_reset();
        req = 4'b0001; op_flat = 8'h01; a_flat = 32'd8; b_flat = 32'd5;
        step(1);
        check("drop_grant", grant, 4'b0001);
        step(1);
        req = '0;
        step(3);
        check("drop_done", done, 4'b0001);
        check("drop_resultado", resultado, 3);
        step(1);
        check("drop_done_clear", done, 0);

        // Minimum latency RES_LAT=1 on the second instance
        req1 = 4'b0001; a_flat1 = 32'd1; b_flat1 = 32'd2;
        step(1);
        check("l1_grant_e0", grant1, 4'b0001);
        step(2);
        check("l1_bv_e2", bus_valido1, 1);
        check("l1_done_e2", done1, 0);
        c1 = 8'h5A;
        step(1);
        check("l1_done_e3", done1, 4'b0001);
        check("l1_resultado_e3", resultado1, 8'h5A);
        check("l1_bv_e3", bus_valido1, 0);
        c1 = 8'h77;
        step(1);
        check("l1_regrant_e4", grant1, 4'b0001);
        check("l1_ocupado_e4", ocupado1, 1);
        check("l1_done_e4", done1, 0);
        check("l1_resultado_hold", resultado1, 8'h5A);
        req1 = '0;
        step(4);
        check("l1_idle", ocupado1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
